oven_sequencer: RTL
===================

OVEN_SEQUENCER -- requirements
Module: oven_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000: clk cycles per one-second countdown tick.
REQ-002 SHALL have parameter TEMP_W, default 10: temperature width.
REQ-003 SHALL have parameter TIME_W, default 13: time width, in seconds.
REQ-004 SHALL have parameter DEFAULT_TEMP, default 300: power-on target temperature.
REQ-005 SHALL have parameters MIN_TEMP 65, MAX_TEMP 500, MAX_TIME 1800: clamp limits.
REQ-006 SHALL have parameter HYST, default 10: hysteresis band below target while cooking.
REQ-007 SHALL have port clk, input, 1 bit: the single clock.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have ports pwr, key0, key1, input, 1 bit each: power switch and two active-low keys (key1 = up, key0 = down).
REQ-010 SHALL have port sw, input, 6 bits: sw[4:0] is a one-hot step select; sw[5] is door-open/pause.
REQ-011 SHALL have port cur_temp, input, TEMP_W bits: measured temperature.
REQ-012 SHALL have ports target_temp (TEMP_W), target_time (TIME_W) and remaining_time (TIME_W), output.
REQ-013 SHALL have ports state (3 bits), heat_en (1 bit) and done_alarm (1 bit), output.

Function
REQ-014 SHALL register each key and detect a falling edge (1->0) as a one-cycle press pulse.
REQ-015 SHALL treat an up press while key0 is high as increment, a down press while key1 is high as decrement, and both keys low on a cycle after they were not both low as one confirm pulse.
REQ-016 SHALL decode step values; any pattern on sw[4:0] other than one-hot gives step 0.
- Temperature steps: sw0..sw4 -> 5, 10, 25, 50, 100.
- Time steps: sw0..sw4 -> 5, 10, 30, 60, 300.
REQ-017 SHALL do all increment/decrement arithmetic at width+1 and clamp the result.
- Increment: a result >= MAX sets the value to MAX.
- Decrement: a result <= MIN (MIN_TEMP for temperature, 0 for time) sets the value to MIN; underflow is never allowed to wrap.
REQ-018 SHALL implement the FSM states OFF=0, SET_TEMP=1, SET_TIME=2, PREHEAT=3, COOK=4, DONE=5.
REQ-019 SHALL go to OFF from any state whenever pwr=0, with the next cycle's outputs equal to the reset values.
REQ-020 SHALL handle OFF as follows: with pwr=1, go to SET_TEMP and load target_temp=DEFAULT_TEMP and target_time=0.
REQ-021 SHALL handle SET_TEMP as follows: increment/decrement adjusts target_temp; confirm goes to SET_TIME.
REQ-022 SHALL handle SET_TIME as follows: increment/decrement adjusts target_time.
- Confirm with target_time>0 goes to PREHEAT.
- Confirm with target_time=0 is ignored.
REQ-023 SHALL handle PREHEAT as follows: heat_en=1; when cur_temp>=target_temp, go to COOK, load remaining_time=target_time and clear the prescaler.
REQ-024 SHALL handle COOK heating with hysteresis: heat_en sets when cur_temp<target_temp-HYST, clears when cur_temp>=target_temp, and otherwise holds.
REQ-025 SHALL count the COOK prescaler from 0 to TICK_DIV-1 and emit a tick as it wraps; each tick decrements remaining_time by 1.
REQ-026 SHALL go to DONE in the same cycle that remaining_time reaches 0.
REQ-027 SHALL pause while in COOK with sw[5]=1: the prescaler and remaining_time hold, heat_en=0, and releasing sw[5] resumes the count without losing progress.
REQ-028 SHALL handle DONE as follows: heat_en=0 and done_alarm=1; confirm goes to SET_TEMP with targets retained and clears done_alarm.
REQ-029 SHALL ignore increment/decrement outside SET_TEMP and SET_TIME.
REQ-030 SHALL register all outputs; a key press affects its target one cycle after the press pulse.

Reset
REQ-031 SHALL, on rst=1 at a clk edge, set state=OFF, target_temp=DEFAULT_TEMP, target_time=0, remaining_time=0, heat_en=0, done_alarm=0, prescaler=0 and key history regs=1.
REQ-032 SHALL give rst priority over pwr and over every key event, including when asserted mid-COOK.

Structure
REQ-033 SHALL take the state encoding, both step tables and the step-decode function from a shared package oven_pkg.
REQ-034 SHALL place key edge detection and confirm generation in sub-module oven_key_edge, instantiated once.

Verification
REQ-035 SHALL cover: pwr=1, sw=00100, two up presses -> target_temp 350; sw=10000, two further up presses -> 500 (clamped).
REQ-036 SHALL cover: in SET_TEMP at 70, sw=00001, down press -> 65; down again -> 65.
REQ-037 SHALL cover: confirm in SET_TIME with target_time=0 -> state stays 2; sw=01000, up, confirm -> state 3.
REQ-038 SHALL cover: TICK_DIV=4, target_time=5, cur_temp forced >= target -> COOK, then DONE after 20 clk cycles with done_alarm=1.
REQ-039 SHALL cover: sw[5]=1 for 10 cycles mid-COOK -> remaining_time frozen and heat_en=0; DONE is delayed by exactly 10 cycles.
REQ-040 SHALL cover: rst pulse during COOK -> next cycle state 0, all outputs at reset values; pwr=0 mid-PREHEAT -> state 0.

Source files
------------

// File: rtl/oven_pkg.sv
// ============================================================================
// oven_pkg : shared FSM encoding, step tables and step decoder
// Revision : 1.0
// ============================================================================
`default_nettype none

package oven_pkg;

  localparam logic [2:0] ST_OFF      = 3'd0;
  localparam logic [2:0] ST_SET_TEMP = 3'd1;
  localparam logic [2:0] ST_SET_TIME = 3'd2;
  localparam logic [2:0] ST_PREHEAT  = 3'd3;
  localparam logic [2:0] ST_COOK     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam int STEP_W = 9;

  localparam logic [STEP_W-1:0] TEMP_STEP [5] = '{9'd5, 9'd10, 9'd25, 9'd50, 9'd100};
  localparam logic [STEP_W-1:0] TIME_STEP [5] = '{9'd5, 9'd10, 9'd30, 9'd60, 9'd300};

  // Anything other than exactly one bit set on the selector yields a zero step.
  function automatic logic [STEP_W-1:0] step_decode(input logic [4:0] sel,
                                                    input logic       is_time);
    logic [STEP_W-1:0] step;
    step = '0;
    for (int i = 0; i < 5; i++) begin
      if (sel == (5'd1 << i)) begin
        step = is_time ? TIME_STEP[i] : TEMP_STEP[i];
      end
    end
    return step;
  endfunction

endpackage

`default_nettype wire

// File: rtl/oven_key_edge.sv
// ============================================================================
// oven_key_edge : active-low key press detection and confirm generation
// Revision      : 1.0
// ============================================================================
`default_nettype none

module oven_key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key0,
  input  logic key1,
  output logic inc,
  output logic dec,
  output logic confirm
);

  logic key0_q;
  logic key1_q;
  logic up_fall;
  logic down_fall;
  logic both_low;
  logic both_low_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      key0_q <= 1'b1;
      key1_q <= 1'b1;
    end else begin
      key0_q <= key0;
      key1_q <= key1;
    end
  end

  assign up_fall    = key1_q & ~key1;
  assign down_fall  = key0_q & ~key0;
  assign both_low   = ~key0 & ~key1;
  assign both_low_q = ~key0_q & ~key1_q;

  // A press only counts as up/down while the other key is released.
  assign inc     = up_fall & key0;
  assign dec     = down_fall & key1;
  assign confirm = both_low & ~both_low_q;

endmodule

`default_nettype wire

// File: rtl/oven_sequencer.sv
// ============================================================================
// oven_sequencer : oven control FSM with clamped setpoints and tick countdown
// Revision       : 1.0
// ============================================================================
`default_nettype none

module oven_sequencer
  import oven_pkg::*;
#(
  parameter int TICK_DIV     = 50000000,
  parameter int TEMP_W       = 10,
  parameter int TIME_W       = 13,
  parameter int DEFAULT_TEMP = 300,
  parameter int MIN_TEMP     = 65,
  parameter int MAX_TEMP     = 500,
  parameter int MAX_TIME     = 1800,
  parameter int HYST         = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwr,
  input  logic              key0,
  input  logic              key1,
  input  logic [5:0]        sw,
  input  logic [TEMP_W-1:0] cur_temp,
  output logic [TEMP_W-1:0] target_temp,
  output logic [TIME_W-1:0] target_time,
  output logic [TIME_W-1:0] remaining_time,
  output logic [2:0]        state,
  output logic              heat_en,
  output logic              done_alarm
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [TEMP_W-1:0] DEF_TEMP_V = TEMP_W'(DEFAULT_TEMP);
  localparam logic [TEMP_W-1:0] MIN_TEMP_V = TEMP_W'(MIN_TEMP);
  localparam logic [TEMP_W-1:0] MAX_TEMP_V = TEMP_W'(MAX_TEMP);
  localparam logic [TIME_W-1:0] MAX_TIME_V = TIME_W'(MAX_TIME);
  localparam logic [TEMP_W:0]   HYST_V     = (TEMP_W+1)'(HYST);

  logic             key_inc;
  logic             key_dec;
  logic             key_confirm;
  logic [PRE_W-1:0] prescaler;

  logic [TEMP_W:0]   temp_step;
  logic [TEMP_W:0]   temp_sum;
  logic [TEMP_W:0]   temp_diff;
  logic [TEMP_W-1:0] temp_inc;
  logic [TEMP_W-1:0] temp_dec;
  logic [TIME_W:0]   time_step;
  logic [TIME_W:0]   time_sum;
  logic [TIME_W:0]   time_diff;
  logic [TIME_W-1:0] time_inc;
  logic [TIME_W-1:0] time_dec;
  logic              temp_reached;
  logic              temp_low;
  logic              tick;

  oven_key_edge u_key_edge (
    .clk     (clk),
    .rst     (rst),
    .key0    (key0),
    .key1    (key1),
    .inc     (key_inc),
    .dec     (key_dec),
    .confirm (key_confirm)
  );

  assign temp_step = (TEMP_W+1)'(step_decode(sw[4:0], 1'b0));
  assign time_step = (TIME_W+1)'(step_decode(sw[4:0], 1'b1));

  // One extra bit lets overflow and underflow be seen before clamping.
  assign temp_sum  = {1'b0, target_temp} + temp_step;
  assign temp_diff = {1'b0, target_temp} - temp_step;
  assign time_sum  = {1'b0, target_time} + time_step;
  assign time_diff = {1'b0, target_time} - time_step;

  assign temp_inc = (temp_sum >= {1'b0, MAX_TEMP_V}) ? MAX_TEMP_V : temp_sum[TEMP_W-1:0];
  assign temp_dec = (temp_diff[TEMP_W] || (temp_diff <= {1'b0, MIN_TEMP_V}))
                    ? MIN_TEMP_V : temp_diff[TEMP_W-1:0];
  assign time_inc = (time_sum >= {1'b0, MAX_TIME_V}) ? MAX_TIME_V : time_sum[TIME_W-1:0];
  assign time_dec = (time_diff[TIME_W] || (time_diff == '0))
                    ? '0 : time_diff[TIME_W-1:0];

  assign temp_reached = (cur_temp >= target_temp);
  assign temp_low     = (({1'b0, cur_temp} + HYST_V) < {1'b0, target_temp});
  assign tick         = (prescaler == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst || !pwr) begin
      state          <= ST_OFF;
      target_temp    <= DEF_TEMP_V;
      target_time    <= '0;
      remaining_time <= '0;
      heat_en        <= 1'b0;
      done_alarm     <= 1'b0;
      prescaler      <= '0;
    end else begin
      case (state)
        ST_OFF: begin
          state       <= ST_SET_TEMP;
          target_temp <= DEF_TEMP_V;
          target_time <= '0;
        end

        ST_SET_TEMP: begin
          if (key_inc) begin
            target_temp <= temp_inc;
          end else if (key_dec) begin
            target_temp <= temp_dec;
          end
          if (key_confirm) begin
            state <= ST_SET_TIME;
          end
        end

        ST_SET_TIME: begin
          if (key_inc) begin
            target_time <= time_inc;
          end else if (key_dec) begin
            target_time <= time_dec;
          end
          if (key_confirm && (target_time != '0)) begin
            state   <= ST_PREHEAT;
            heat_en <= 1'b1;
          end
        end

        ST_PREHEAT: begin
          heat_en <= ~temp_reached;
          if (temp_reached) begin
            state          <= ST_COOK;
            remaining_time <= target_time;
            prescaler      <= '0;
          end
        end

        ST_COOK: begin
          if (sw[5]) begin
            heat_en <= 1'b0;
          end else begin
            if (temp_low) begin
              heat_en <= 1'b1;
            end else if (temp_reached) begin
              heat_en <= 1'b0;
            end

            if (tick) begin
              prescaler      <= '0;
              remaining_time <= remaining_time - 1'b1;
              if (remaining_time <= TIME_W'(1)) begin
                state      <= ST_DONE;
                heat_en    <= 1'b0;
                done_alarm <= 1'b1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
        end

        ST_DONE: begin
          heat_en    <= 1'b0;
          done_alarm <= 1'b1;
          if (key_confirm) begin
            state      <= ST_SET_TEMP;
            done_alarm <= 1'b0;
          end
        end

        default: begin
          state   <= ST_OFF;
          heat_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
